bp_gshare_btb: RTL

BP_GSHARE_BTB -- requirements
Module: bp_gshare_btb

---
 rtl/bp_gshare_btb.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/bp_gshare_btb.sv
// Gshare direction predictor (2-bit counters, PC xor global history) with an optional
// direct-mapped BTB, enabled by defining BP_BTB_EN. Predictions are registered: 1-cycle latency.
module bp_gshare_btb #(
    parameter int PC_W      = 32,
    parameter int IDX_W     = 8,
    parameter int GHR_W     = 8,
    parameter int BTB_IDX_W = 6,
    parameter int TAG_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookup_valid,
    input  logic [PC_W-1:0]  lookup_pc,
    input  logic             lookup_uncond,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    output logic             pred_hit,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic [PC_W-1:0]  upd_target,
    input  logic             upd_taken,
    input  logic             upd_uncond,
    input  logic [GHR_W-1:0] upd_ghr
);
    localparam int PHT_N = 1 << IDX_W;

    function automatic logic [IDX_W-1:0] pht_idx(input logic [PC_W-1:0] pc,
                                                 input logic [GHR_W-1:0] g);
        logic [IDX_W-1:0] g_ext;
        g_ext = '0;
        g_ext[GHR_W-1:0] = g;
        return pc[IDX_W+1:2] ^ g_ext;
    endfunction

    logic [1:0]       pht_q [PHT_N];
    logic [1:0]       pht_d [PHT_N];
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [GHR_W:0]   ghr_shift;
    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [1:0]       lk_cnt;

    logic             pred_valid_q, pred_valid_d;
    logic             pred_taken_q, pred_taken_d;
    logic             pred_hit_q, pred_hit_d;
    logic [PC_W-1:0]  pred_target_q, pred_target_d;
    logic [GHR_W-1:0] pred_ghr_q, pred_ghr_d;

    logic             lk_hit;
    logic [PC_W-1:0]  lk_tgt;

    assign lk_idx    = pht_idx(lookup_pc, ghr_q);
    assign up_idx    = pht_idx(upd_pc, upd_ghr);
    assign lk_cnt    = pht_q[lk_idx];
    assign ghr_shift = {ghr_q, upd_taken};

    // Jumps never train the PHT or the history; only conditional branches do.
    always_comb begin
        pht_d = pht_q;
        ghr_d = ghr_q;
        if (upd_valid && !upd_uncond) begin
            if (upd_taken && pht_q[up_idx] != 2'b11)
                pht_d[up_idx] = pht_q[up_idx] + 2'd1;
            else if (!upd_taken && pht_q[up_idx] != 2'b00)
                pht_d[up_idx] = pht_q[up_idx] - 2'd1;
            ghr_d = ghr_shift[GHR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
            ghr_q <= '0;
        end else begin
            pht_q <= pht_d;
            ghr_q <= ghr_d;
        end
    end

`ifdef BP_BTB_EN
    localparam int BTB_N = 1 << BTB_IDX_W;

    logic                 btb_vld_q [BTB_N];
    logic                 btb_vld_d [BTB_N];
    logic [TAG_W-1:0]     btb_tag_q [BTB_N];
    logic [PC_W-1:0]      btb_tgt_q [BTB_N];
    logic [BTB_IDX_W-1:0] lk_bidx, up_bidx;
    logic [TAG_W-1:0]     lk_tag, up_tag;
    logic                 btb_we;
    logic                 unused_pc_bits;

    assign lk_bidx = lookup_pc[BTB_IDX_W+1:2];
    assign up_bidx = upd_pc[BTB_IDX_W+1:2];
    assign lk_tag  = lookup_pc[BTB_IDX_W+2+TAG_W-1:BTB_IDX_W+2];
    assign up_tag  = upd_pc[BTB_IDX_W+2+TAG_W-1:BTB_IDX_W+2];
    assign btb_we  = upd_valid && upd_taken;
    assign lk_hit  = btb_vld_q[lk_bidx] && (btb_tag_q[lk_bidx] == lk_tag);
    assign lk_tgt  = lk_hit ? btb_tgt_q[lk_bidx] : '0;
    assign unused_pc_bits = ^{lookup_pc, upd_pc};

    always_comb begin
        btb_vld_d = btb_vld_q;
        if (btb_we) btb_vld_d[up_bidx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_N; i++) btb_vld_q[i] <= 1'b0;
        end else begin
            btb_vld_q <= btb_vld_d;
        end
    end

    // Tag/target payload is qualified by the valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (btb_we && !rst) begin
            btb_tag_q[up_bidx] <= up_tag;
            btb_tgt_q[up_bidx] <= upd_target;
        end
    end

    assign pred_taken_d = lookup_valid ? (lk_hit && (lookup_uncond || lk_cnt[1])) : pred_taken_q;
`else
    logic unused_btb_inputs;

    assign lk_hit = 1'b0;
    assign lk_tgt = '0;
    assign unused_btb_inputs = ^{upd_target, lookup_pc, upd_pc};
    assign pred_taken_d = lookup_valid ? (lookup_uncond || lk_cnt[1]) : pred_taken_q;
`endif

    // Response fields hold their last value between lookups.
    always_comb begin
        pred_valid_d  = lookup_valid;
        pred_hit_d    = lookup_valid ? lk_hit : pred_hit_q;
        pred_target_d = lookup_valid ? lk_tgt : pred_target_q;
        pred_ghr_d    = lookup_valid ? ghr_q  : pred_ghr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_target_q <= '0;
            pred_ghr_q    <= '0;
        end else begin
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_hit_q    <= pred_hit_d;
            pred_target_q <= pred_target_d;
            pred_ghr_q    <= pred_ghr_d;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign pred_hit    = pred_hit_q;
    assign pred_target = pred_target_q;
    assign pred_ghr    = pred_ghr_q;
endmodule
